// File: rtl/serial_cmd_sequencer.sv
// serial_cmd_sequencer
//
// Turns the UART receive byte stream into configuration write transactions
// for the multi-channel serial-output array. One single-cycle write strobe
// is issued per complete, valid packet. Malformed packets and unknown
// opcodes raise a one-cycle error strobe.
//
// Optional feature macro: CMD_TIMEOUT_EN
//   When defined, an inter-byte idle counter aborts a partial packet after
//   TIMEOUT_CYCLES clocks without a byte and pulses err_o.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous reset, active-high
//   data_i         in   received byte, valid with rx_done_tick_i
//   rx_done_tick_i in   one-cycle byte-valid strobe
//   wr_en_o        out  one-cycle write strobe
//   wr_type_o      out  1=DATA 2=CTRL 3=FREQ 4=PERIOD 5=REPEAT 6=GLOBAL
//   wr_addr_o      out  channel index (0 for FREQ/PERIOD/GLOBAL)
//   wr_data_o      out  write payload, zero-extended
//   global_stop_o  out  registered global stop bit
//   busy_o         out  high while a packet is in progress
//   err_o          out  one-cycle error strobe

module serial_cmd_sequencer #(
    parameter int         DATA_BIT       = 32,
    parameter int         OUTPUT_NUM     = 16,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] OP_DATA        = 8'h01,
    parameter logic [7:0] OP_CTRL        = 8'h02,
    parameter logic [7:0] OP_FREQ        = 8'h03,
    parameter logic [7:0] OP_PERIOD      = 8'h04,
    parameter logic [7:0] OP_REPEAT      = 8'h05,
    parameter logic [7:0] OP_GLOBAL      = 8'h06
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          data_i,
    input  logic                rx_done_tick_i,
    output logic                wr_en_o,
    output logic [2:0]          wr_type_o,
    output logic [7:0]          wr_addr_o,
    output logic [DATA_BIT-1:0] wr_data_o,
    output logic                global_stop_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int NBYTES = DATA_BIT / 8;

    localparam logic [2:0] TY_NONE   = 3'd0;
    localparam logic [2:0] TY_DATA   = 3'd1;
    localparam logic [2:0] TY_CTRL   = 3'd2;
    localparam logic [2:0] TY_FREQ   = 3'd3;
    localparam logic [2:0] TY_PERIOD = 3'd4;
    localparam logic [2:0] TY_REPEAT = 3'd5;
    localparam logic [2:0] TY_GLOBAL = 3'd6;

    // Elaboration-time parameter legality checks.
    if (DATA_BIT < 8 || DATA_BIT > 64 || (DATA_BIT % 8) != 0) begin : g_bad_data_bit
        $error("serial_cmd_sequencer: DATA_BIT must be a multiple of 8 in 8..64");
    end
    if (OUTPUT_NUM < 1 || OUTPUT_NUM > 256) begin : g_bad_output_num
        $error("serial_cmd_sequencer: OUTPUT_NUM must be in 1..256");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("serial_cmd_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        CHAN,
        AMOUNT,
        PAYLOAD,
        PARAM,
        COMMIT
    } state_t;

    state_t              state;
    logic [2:0]          op;
    logic [7:0]          ch;
    logic [7:0]          amount;
    logic [7:0]          idx;
    logic [7:0]          slow;
    logic                bad;
    logic [DATA_BIT-1:0] payload;
    logic [DATA_BIT-1:0] payload_next;
    logic [2:0]          opcode_type;
    logic                ch_bad;
    logic                amount_bad;
    logic                expired;

    function automatic logic [2:0] decode(input logic [7:0] b);
        if (b == OP_DATA)   return TY_DATA;
        if (b == OP_CTRL)   return TY_CTRL;
        if (b == OP_FREQ)   return TY_FREQ;
        if (b == OP_PERIOD) return TY_PERIOD;
        if (b == OP_REPEAT) return TY_REPEAT;
        if (b == OP_GLOBAL) return TY_GLOBAL;
        return TY_NONE;
    endfunction

    assign opcode_type = decode(data_i);
    // 9-bit compare so OUTPUT_NUM = 256 still works.
    assign ch_bad      = ({1'b0, data_i} >= 9'(OUTPUT_NUM));
    assign amount_bad  = (data_i >= 8'(NBYTES));
    assign busy_o      = (state != IDLE);

    // Payload with the current byte merged in, so the final byte can be
    // committed in the same edge that samples it. Bytes past the register
    // width fall through the loop and are discarded.
    always_comb begin
        payload_next = payload;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == 8'(i)) begin
                payload_next[8*i +: 8] = data_i;
            end
        end
    end

`ifdef CMD_TIMEOUT_EN
    logic [31:0] idle_cnt;

    // Idle counter runs only while waiting for bytes inside a packet.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            idle_cnt <= 32'd0;
        end else if (rx_done_tick_i || state == IDLE || state == COMMIT || expired) begin
            idle_cnt <= 32'd0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    // A byte arriving in the expiry cycle wins over the timeout.
    assign expired = (state != IDLE) && (state != COMMIT) && !rx_done_tick_i &&
                     (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign expired = 1'b0;
`endif

    // Packet parser. COMMIT shares the IDLE opcode handling so that a byte
    // arriving during the commit cycle is taken as the next opcode.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= IDLE;
            op            <= TY_NONE;
            ch            <= 8'd0;
            amount        <= 8'd0;
            idx           <= 8'd0;
            slow          <= 8'd0;
            bad           <= 1'b0;
            payload       <= '0;
            wr_en_o       <= 1'b0;
            wr_type_o     <= 3'd0;
            wr_addr_o     <= 8'd0;
            wr_data_o     <= '0;
            global_stop_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            wr_en_o <= 1'b0;
            err_o   <= 1'b0;
            if (expired) begin
                state <= IDLE;
                err_o <= 1'b1;
            end else begin
                case (state)
                    IDLE, COMMIT: begin
                        state <= IDLE;
                        if (rx_done_tick_i) begin
                            op  <= opcode_type;
                            bad <= 1'b0;
                            idx <= 8'd0;
                            case (opcode_type)
                                TY_DATA, TY_CTRL, TY_REPEAT: state <= CHAN;
                                TY_FREQ:                     state <= AMOUNT;
                                TY_PERIOD, TY_GLOBAL:        state <= PARAM;
                                default:                     err_o <= 1'b1;
                            endcase
                        end
                    end
                    CHAN: begin
                        if (rx_done_tick_i) begin
                            ch    <= data_i;
                            bad   <= ch_bad;
                            state <= (op == TY_DATA) ? AMOUNT : PARAM;
                        end
                    end
                    AMOUNT: begin
                        if (rx_done_tick_i) begin
                            amount  <= data_i;
                            bad     <= bad | amount_bad;
                            payload <= '0;
                            idx     <= 8'd0;
                            state   <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (rx_done_tick_i) begin
                            payload <= payload_next;
                            idx     <= idx + 8'd1;
                            // idx == amount marks byte N, the last of N+1.
                            if (idx == amount) begin
                                state <= COMMIT;
                                if (bad) begin
                                    err_o <= 1'b1;
                                end else begin
                                    wr_en_o   <= 1'b1;
                                    wr_type_o <= op;
                                    wr_addr_o <= (op == TY_DATA) ? ch : 8'd0;
                                    wr_data_o <= payload_next;
                                end
                            end
                        end
                    end
                    PARAM: begin
                        if (rx_done_tick_i) begin
                            if (op == TY_PERIOD && idx == 8'd0) begin
                                slow <= data_i;
                                idx  <= 8'd1;
                            end else begin
                                state <= COMMIT;
                                if (bad) begin
                                    err_o <= 1'b1;
                                end else begin
                                    wr_en_o   <= 1'b1;
                                    wr_type_o <= op;
                                    wr_addr_o <= (op == TY_CTRL || op == TY_REPEAT) ? ch : 8'd0;
                                    if (op == TY_PERIOD) begin
                                        wr_data_o <= DATA_BIT'({slow, data_i});
                                    end else begin
                                        wr_data_o <= DATA_BIT'(data_i);
                                    end
                                    if (op == TY_GLOBAL) begin
                                        global_stop_o <= data_i[0];
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_cmd_sequencer.sv
// tb_serial_cmd_sequencer
//
// Self-checking bench for serial_cmd_sequencer (default build). Expected
// writes are pushed to a scoreboard queue as each packet is driven and
// popped in the cycle the strobe must appear. Bytes are driven on the
// falling edge; outputs are sampled on the falling edge after the rising
// edge that consumed the last byte.

module tb_serial_cmd_sequencer;

    localparam int DATA_BIT = 32;

    typedef struct packed {
        logic [2:0]          typ;
        logic [7:0]          addr;
        logic [DATA_BIT-1:0] data;
    } wr_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [7:0]          data_i;
    logic                rx_done_tick_i;
    logic                wr_en_o;
    logic [2:0]          wr_type_o;
    logic [7:0]          wr_addr_o;
    logic [DATA_BIT-1:0] wr_data_o;
    logic                global_stop_o;
    logic                busy_o;
    logic                err_o;

    int  compared   = 0;
    int  mismatched = 0;
    int  wr_seen    = 0;
    int  err_seen   = 0;
    int  exp_wr     = 0;
    int  exp_err    = 0;
    wr_t sb[$];

    serial_cmd_sequencer #(.DATA_BIT(DATA_BIT), .OUTPUT_NUM(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_i         (data_i),
        .rx_done_tick_i (rx_done_tick_i),
        .wr_en_o        (wr_en_o),
        .wr_type_o      (wr_type_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .global_stop_o  (global_stop_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    // Strobe counters; sampled at the rising edge so each pulse counts once.
    always @(posedge clk) begin
        if (wr_en_o === 1'b1) wr_seen++;
        if (err_o === 1'b1) err_seen++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Bytes listed first-arrival-first in the most significant positions.
    task automatic send_packet(input logic [63:0] bytes, input int n, input bit drop);
        for (int i = 0; i < n; i++) begin
            data_i         = bytes[8*(n-1-i) +: 8];
            rx_done_tick_i = 1'b1;
            @(negedge clk);
        end
        if (drop) rx_done_tick_i = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_done_tick_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [2:0] typ, input logic [7:0] addr, input logic [DATA_BIT-1:0] data);
        sb.push_back({typ, addr, data});
        exp_wr++;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        data_i         = 8'h00;
        rx_done_tick_i = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({wr_en_o, wr_type_o, wr_addr_o, wr_data_o, global_stop_o, busy_o, err_o} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: got en=%b type=%0d addr=%0d data=%h gs=%b busy=%b err=%b, want all 0",
                     wr_en_o, wr_type_o, wr_addr_o, wr_data_o, global_stop_o, busy_o, err_o);
        end
        rst_n = 1'b0;
        @(negedge clk);
        compared++;
        if ({wr_en_o, wr_type_o, wr_addr_o, wr_data_o, global_stop_o, busy_o, err_o} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_release: got en=%b type=%0d busy=%b err=%b, want all 0",
                     wr_en_o, wr_type_o, busy_o, err_o);
        end
    endtask

    task automatic test_data();
        wr_t exp;
        int  w0 = wr_seen;
        int  e0 = err_seen;
        push_exp(3'd1, 8'd0, 32'h5500_5500);
        send_packet({8'h01, 8'h00, 8'h03, 8'h00, 8'h55, 8'h00, 8'h55}, 7, 1'b1);
        exp = sb.pop_front();
        compared++;
        if ({wr_en_o, err_o, wr_type_o, wr_addr_o, wr_data_o} !== {1'b1, 1'b0, exp}) begin
            mismatched++;
            $display("[TB] FAIL data_write: got en=%b err=%b type=%0d addr=%0d data=%h, want en=1 err=0 type=%0d addr=%0d data=%h",
                     wr_en_o, err_o, wr_type_o, wr_addr_o, wr_data_o, exp.typ, exp.addr, exp.data);
        end
        idle(3);
        compared++;
        if ((wr_seen - w0) !== 1 || (err_seen - e0) !== 0 || busy_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL data_single_strobe: got writes=%0d errs=%0d busy=%b, want 1 0 0",
                     wr_seen - w0, err_seen - e0, busy_o);
        end
    endtask

    task automatic test_ctrl_global();
        wr_t exp;
        push_exp(3'd2, 8'd15, 32'd5);
        send_packet({8'h02, 8'h0F, 8'h05}, 3, 1'b1);
        exp = sb.pop_front();
        compared++;
        if ({wr_en_o, err_o, wr_type_o, wr_addr_o, wr_data_o} !== {1'b1, 1'b0, exp}) begin
            mismatched++;
            $display("[TB] FAIL ctrl_write: got en=%b err=%b type=%0d addr=%0d data=%h, want type=%0d addr=%0d data=%h",
                     wr_en_o, err_o, wr_type_o, wr_addr_o, wr_data_o, exp.typ, exp.addr, exp.data);
        end
        idle(1);
        push_exp(3'd6, 8'd0, 32'd1);
        send_packet({8'h06, 8'h01}, 2, 1'b1);
        exp = sb.pop_front();
        compared++;
        if ({wr_en_o, wr_type_o, wr_addr_o, wr_data_o, global_stop_o} !== {1'b1, exp, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL global_write: got en=%b type=%0d addr=%0d data=%h gs=%b, want type=%0d addr=%0d data=%h gs=1",
                     wr_en_o, wr_type_o, wr_addr_o, wr_data_o, global_stop_o, exp.typ, exp.addr, exp.data);
        end
        idle(3);
        compared++;
        if (global_stop_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL global_stop_hold: got %b want 1", global_stop_o);
        end
    endtask

    task automatic test_invalid_channel();
        wr_t exp;
        send_packet({8'h02, 8'h10, 8'h05}, 3, 1'b1);
        exp_err++;
        compared++;
        if ({wr_en_o, err_o, busy_o} !== 3'b011) begin
            mismatched++;
            $display("[TB] FAIL invalid_ch_commit: got en=%b err=%b busy=%b, want en=0 err=1 busy=1",
                     wr_en_o, err_o, busy_o);
        end
        compared++;
        if ({wr_type_o, wr_addr_o, wr_data_o} !== {3'd6, 8'd0, 32'd1}) begin
            mismatched++;
            $display("[TB] FAIL invalid_ch_hold: got type=%0d addr=%0d data=%h, want type=6 addr=0 data=1",
                     wr_type_o, wr_addr_o, wr_data_o);
        end
        idle(1);
        push_exp(3'd4, 8'd0, 32'h0000_1405);
        send_packet({8'h04, 8'h14, 8'h05}, 3, 1'b1);
        exp = sb.pop_front();
        compared++;
        if ({wr_en_o, err_o, wr_type_o, wr_addr_o, wr_data_o} !== {1'b1, 1'b0, exp}) begin
            mismatched++;
            $display("[TB] FAIL period_write: got en=%b err=%b type=%0d addr=%0d data=%h, want type=%0d addr=%0d data=%h",
                     wr_en_o, err_o, wr_type_o, wr_addr_o, wr_data_o, exp.typ, exp.addr, exp.data);
        end
        idle(1);
    endtask

    task automatic test_unknown_opcode();
        wr_t exp;
        send_packet({56'd0, 8'h07}, 1, 1'b1);
        exp_err++;
        compared++;
        if ({err_o, busy_o, wr_en_o} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL unknown_op_err: got err=%b busy=%b en=%b, want err=1 busy=0 en=0",
                     err_o, busy_o, wr_en_o);
        end
        idle(1);
        compared++;
        if ({err_o, busy_o} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL unknown_op_pulse: got err=%b busy=%b, want 0 0", err_o, busy_o);
        end
        push_exp(3'd5, 8'd3, 32'd10);
        send_packet({8'h05, 8'h03, 8'h0A}, 3, 1'b1);
        exp = sb.pop_front();
        compared++;
        if ({wr_en_o, err_o, wr_type_o, wr_addr_o, wr_data_o} !== {1'b1, 1'b0, exp}) begin
            mismatched++;
            $display("[TB] FAIL repeat_write: got en=%b err=%b type=%0d addr=%0d data=%h, want type=%0d addr=%0d data=%h",
                     wr_en_o, err_o, wr_type_o, wr_addr_o, wr_data_o, exp.typ, exp.addr, exp.data);
        end
        idle(1);
    endtask

    task automatic test_freq();
        wr_t exp;
        // N=4 is one past the widest payload: consumed, then rejected.
        send_packet({8'h03, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 7, 1'b1);
        exp_err++;
        compared++;
        if ({wr_en_o, err_o} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL freq_oversize: got en=%b err=%b, want en=0 err=1", wr_en_o, err_o);
        end
        idle(1);
        push_exp(3'd3, 8'd0, 32'h0000_CDAB);
        send_packet({8'h03, 8'h01, 8'hAB, 8'hCD}, 4, 1'b1);
        exp = sb.pop_front();
        compared++;
        if ({wr_en_o, err_o, wr_type_o, wr_addr_o, wr_data_o} !== {1'b1, 1'b0, exp}) begin
            mismatched++;
            $display("[TB] FAIL freq_write: got en=%b err=%b type=%0d addr=%0d data=%h, want type=%0d addr=%0d data=%h",
                     wr_en_o, err_o, wr_type_o, wr_addr_o, wr_data_o, exp.typ, exp.addr, exp.data);
        end
        idle(1);
    endtask

    task automatic test_long_payload();
        wr_t exp;
        int  e0 = err_seen;
        send_packet({8'h01, 8'h00, 8'hFF}, 3, 1'b0);
        for (int i = 0; i < 255; i++) begin
            data_i = 8'(i);
            @(negedge clk);
        end
        idle(1);
        compared++;
        if (busy_o !== 1'b1 || (err_seen - e0) !== 0) begin
            mismatched++;
            $display("[TB] FAIL long_in_progress: got busy=%b errs=%0d, want busy=1 errs=0", busy_o, err_seen - e0);
        end
        send_packet({56'd0, 8'hFF}, 1, 1'b1);
        exp_err++;
        compared++;
        if ({wr_en_o, err_o} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL long_commit: got en=%b err=%b, want en=0 err=1", wr_en_o, err_o);
        end
        idle(1);
        push_exp(3'd6, 8'd0, 32'd0);
        send_packet({8'h06, 8'h00}, 2, 1'b1);
        exp = sb.pop_front();
        compared++;
        if ({wr_en_o, wr_type_o, wr_addr_o, wr_data_o, global_stop_o} !== {1'b1, exp, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL after_long_global: got en=%b type=%0d data=%h gs=%b, want en=1 type=6 data=0 gs=0",
                     wr_en_o, wr_type_o, wr_data_o, global_stop_o);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        wr_t exp;
        push_exp(3'd2, 8'd1, 32'h0000_00AA);
        push_exp(3'd5, 8'd2, 32'd7);
        push_exp(3'd1, 8'd15, 32'h0000_BEEF);
        send_packet({8'h02, 8'h01, 8'hAA}, 3, 1'b0);
        exp = sb.pop_front();
        compared++;
        if ({wr_en_o, wr_type_o, wr_addr_o, wr_data_o} !== {1'b1, exp}) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got en=%b type=%0d addr=%0d data=%h, want type=%0d addr=%0d data=%h",
                     wr_en_o, wr_type_o, wr_addr_o, wr_data_o, exp.typ, exp.addr, exp.data);
        end
        send_packet({8'h05, 8'h02, 8'h07}, 3, 1'b0);
        exp = sb.pop_front();
        compared++;
        if ({wr_en_o, wr_type_o, wr_addr_o, wr_data_o} !== {1'b1, exp}) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got en=%b type=%0d addr=%0d data=%h, want type=%0d addr=%0d data=%h",
                     wr_en_o, wr_type_o, wr_addr_o, wr_data_o, exp.typ, exp.addr, exp.data);
        end
        send_packet({8'h01, 8'h0F, 8'h01, 8'hEF, 8'hBE}, 5, 1'b1);
        exp = sb.pop_front();
        compared++;
        if ({wr_en_o, wr_type_o, wr_addr_o, wr_data_o} !== {1'b1, exp}) begin
            mismatched++;
            $display("[TB] FAIL b2b_third: got en=%b type=%0d addr=%0d data=%h, want type=%0d addr=%0d data=%h",
                     wr_en_o, wr_type_o, wr_addr_o, wr_data_o, exp.typ, exp.addr, exp.data);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_packet();
        wr_t exp;
        int  w0 = wr_seen;
        send_packet({8'h01, 8'h00, 8'h03, 8'h11, 8'h22}, 5, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({wr_en_o, wr_type_o, wr_addr_o, wr_data_o, global_stop_o, busy_o, err_o} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid: got en=%b type=%0d addr=%0d data=%h busy=%b err=%b, want all 0",
                     wr_en_o, wr_type_o, wr_addr_o, wr_data_o, busy_o, err_o);
        end
        rst_n = 1'b0;
        @(negedge clk);
        push_exp(3'd2, 8'd3, 32'd4);
        send_packet({8'h02, 8'h03, 8'h04}, 3, 1'b1);
        exp = sb.pop_front();
        compared++;
        if ({wr_en_o, wr_type_o, wr_addr_o, wr_data_o} !== {1'b1, exp}) begin
            mismatched++;
            $display("[TB] FAIL after_reset_write: got en=%b type=%0d addr=%0d data=%h, want type=%0d addr=%0d data=%h",
                     wr_en_o, wr_type_o, wr_addr_o, wr_data_o, exp.typ, exp.addr, exp.data);
        end
        idle(2);
        compared++;
        if ((wr_seen - w0) !== 1) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_strobes: got %0d writes, want 1", wr_seen - w0);
        end
    endtask

    task automatic test_totals();
        idle(2);
        compared++;
        if (wr_seen !== exp_wr || err_seen !== exp_err) begin
            mismatched++;
            $display("[TB] FAIL strobe_totals: got writes=%0d errs=%0d, want writes=%0d errs=%0d",
                     wr_seen, err_seen, exp_wr, exp_err);
        end
    endtask

    initial begin
        $display("[TB] serial_cmd_sequencer bench start");
        test_reset();
        test_data();
        test_ctrl_global();
        test_invalid_channel();
        test_unknown_opcode();
        test_freq();
        test_long_payload();
        test_back_to_back();
        test_reset_mid_packet();
        test_totals();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
